instr_fetch: RTL and testbench
==============================

INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have one clock and one reset: CLK is the only clock; Reset_n is asynchronous and active-low.
REQ-002 Parameter: PC_W, default 10, program-counter and instruction-memory address width.
REQ-003 Parameter: INSTR_W, default 9, instruction width; Opcode = Instr[8:6], Func = Instr[5:3].
REQ-004 CLK  in  1  rising-edge system clock.
REQ-005 Reset_n  in  1  asynchronous active-low reset.
REQ-006 Start  in  1  begin execution at StartAddr; honoured in IDLE and HALT only.
REQ-007 StartAddr  in  PC_W  first instruction address.
REQ-008 IMemAddr  out  PC_W  instruction-memory address; memory samples it at the rising edge, data valid during the following cycle.
REQ-009 IMemRdata  in  INSTR_W  instruction-memory read data.
REQ-010 Instr  out  INSTR_W  current instruction to the Control decoder; 0 when InstrValid=0.
REQ-011 InstrValid  out  1  Instr is a live instruction this cycle.
REQ-012 Stall  in  1  hold current instruction; no PC advance.
REQ-013 branch, branchEq, branchLT  in  1 each  Control decode of the current Instr.
REQ-014 EqFlag, LtFlag  in  1 each  registered ALU compare flags.
REQ-015 BranchTarget  in  PC_W  branch destination from the register file.
REQ-016 done  in  1  Control decode: current Instr is the halt instruction.
REQ-017 PC  out  PC_W  address of the current Instr.
REQ-018 Halted  out  1  program finished.
REQ-019 RetireCount  out  16  instructions retired since the last Start.

Function
REQ-020 FSM states SHALL be IDLE, RUN, HALT.
REQ-021 IDLE: IMemAddr=StartAddr; Start=1 -> PC<=StartAddr, RetireCount<=0, state<=RUN.
REQ-022 RUN: InstrValid=1, Instr=IMemRdata (combinational pass-through).
REQ-023 RUN taken = branch & ((~branchEq & ~branchLT) | (branchEq & EqFlag) | (branchLT & LtFlag)).
REQ-024 RUN next-PC = BranchTarget if taken, else PC+1 modulo 2^PC_W (0x3FF+1 -> 0x000).
REQ-025 RUN, Stall=0, done=0: IMemAddr=next-PC; PC<=next-PC; RetireCount+1, saturating at 0xFFFF.
REQ-026 RUN, Stall=1: IMemAddr=PC; PC, state, RetireCount hold; branch and done ignored.
REQ-027 RUN, Stall=0, done=1: state<=HALT, RetireCount+1 (saturating), PC holds; done overrides a simultaneous taken branch.
REQ-028 Taken branches SHALL incur zero bubbles: target instruction is valid in the cycle after the branch.
REQ-029 HALT: InstrValid=0, Halted=1, IMemAddr=StartAddr, PC and RetireCount hold; Start=1 -> same action as REQ-021, Halted=0 from the next cycle.
REQ-030 Start in RUN SHALL be ignored.
REQ-031 Halted=0 in IDLE and RUN; InstrValid=0 in IDLE and HALT.

Reset
REQ-032 Reset_n=0 SHALL immediately, without a clock edge, force state=IDLE, PC=0, RetireCount=0, InstrValid=0, Halted=0, Instr=0.
REQ-033 Reset asserted in RUN or HALT SHALL abort execution; the first clock edge after deassertion SHALL evaluate IDLE rules.

Verification
REQ-034 Reset, StartAddr=0x010, Start 1 cycle, memory holds 3 non-branch instructions then done -> PC 0x010,0x011,0x012,0x013 on consecutive cycles, Halted=1 next cycle, RetireCount=4.
REQ-035 At PC=0x020, branch=1, branchEq=1, EqFlag=1, BranchTarget=0x005 -> next cycle PC=0x005, InstrValid=1; repeat with EqFlag=0 -> PC=0x021.
REQ-036 branchLT=1, LtFlag=1, BranchTarget=0x3FE; then two sequential instructions -> PC 0x3FE, 0x3FF, 0x000.
REQ-037 Stall held 3 cycles at PC=0x030 -> PC, Instr, RetireCount constant; after release PC=0x031.
REQ-038 done=1 and taken branch same cycle -> HALT, PC holds; Start with StartAddr=0x100 in HALT -> RUN at PC=0x100, RetireCount restarts from 0.
REQ-039 Reset_n pulsed low mid-RUN between clock edges -> InstrValid=0, PC=0 immediately; Start afterwards restarts cleanly.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch unit: owns the program counter, drives the instruction
// memory address, presents the current instruction to Control and counts
// retired instructions. Taken branches redirect the fetch address
// combinationally, so the target instruction is live the very next cycle.
module instr_fetch #(
    parameter int unsigned PC_W    = 10,
    parameter int unsigned INSTR_W = 9
) (
    input  logic               CLK,
    input  logic               Reset_n,
    input  logic               Start,
    input  logic [PC_W-1:0]    StartAddr,
    output logic [PC_W-1:0]    IMemAddr,
    input  logic [INSTR_W-1:0] IMemRdata,
    output logic [INSTR_W-1:0] Instr,
    output logic               InstrValid,
    input  logic               Stall,
    input  logic               branch,
    input  logic               branchEq,
    input  logic               branchLT,
    input  logic               EqFlag,
    input  logic               LtFlag,
    input  logic [PC_W-1:0]    BranchTarget,
    input  logic               done,
    output logic [PC_W-1:0]    PC,
    output logic               Halted,
    output logic [15:0]        RetireCount
);

    localparam int unsigned CNT_W = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetchState_t;

    fetchState_t      state;
    fetchState_t      stateNext;
    logic [PC_W-1:0]  pcReg;
    logic [PC_W-1:0]  pcNext;
    logic [PC_W-1:0]  fetchPc;
    logic [CNT_W-1:0] retireReg;
    logic [CNT_W-1:0] retireNext;
    logic [CNT_W-1:0] retireInc;
    logic             taken;

    // Branch resolution: unconditional when no condition is selected
    always_comb begin
        taken = branch & ((~branchEq & ~branchLT)
                        | (branchEq & EqFlag)
                        | (branchLT & LtFlag));
    end

    // Sequential or redirected successor address, and saturating retire count
    always_comb begin
        fetchPc   = taken ? BranchTarget : pcReg + PC_W'(1);
        retireInc = (retireReg == CNT_MAX) ? retireReg : retireReg + CNT_W'(1);
    end

    // State register, PC and retire counter
    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            state     <= IDLE;
            pcReg     <= '0;
            retireReg <= '0;
        end else begin
            state     <= stateNext;
            pcReg     <= pcNext;
            retireReg <= retireNext;
        end
    end

    // Next-state logic and fetch address selection
    always_comb begin
        stateNext  = state;
        pcNext     = pcReg;
        retireNext = retireReg;
        IMemAddr   = StartAddr;
        case (state)
            IDLE, HALT: begin
                if (Start) begin
                    stateNext  = RUN;
                    pcNext     = StartAddr;
                    retireNext = '0;
                end
            end
            RUN: begin
                if (Stall) begin
                    // Re-fetch the current address so Instr stays put
                    IMemAddr = pcReg;
                end else if (done) begin
                    // Halt wins over any branch decoded alongside it
                    stateNext  = HALT;
                    retireNext = retireInc;
                    IMemAddr   = pcReg;
                end else begin
                    IMemAddr   = fetchPc;
                    pcNext     = fetchPc;
                    retireNext = retireInc;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    // Status outputs decode directly from the state register
    always_comb begin
        InstrValid  = (state == RUN);
        Halted      = (state == HALT);
        Instr       = InstrValid ? IMemRdata : '0;
        PC          = pcReg;
        RetireCount = retireReg;
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized scoreboard bench for instr_fetch with an ISA-level reference model.
module tb_instr_fetch;

    localparam int unsigned PC_W    = 10;
    localparam int unsigned INSTR_W = 9;
    localparam int unsigned MEM_N   = 1 << PC_W;
    localparam int          RUN_MAX = 500;

    typedef struct {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
        logic [15:0]        ret;
    } expEntry_t;

    logic               CLK = 1'b0;
    logic               Reset_n;
    logic               Start;
    logic [PC_W-1:0]    StartAddr;
    logic [PC_W-1:0]    IMemAddr;
    logic [INSTR_W-1:0] IMemRdata;
    logic [INSTR_W-1:0] Instr;
    logic               InstrValid;
    logic               Stall;
    logic               branch;
    logic               branchEq;
    logic               branchLT;
    logic               EqFlag;
    logic               LtFlag;
    logic [PC_W-1:0]    BranchTarget;
    logic               done;
    logic [PC_W-1:0]    PC;
    logic               Halted;
    logic [15:0]        RetireCount;

    logic [INSTR_W-1:0] mem [MEM_N];
    logic [PC_W-1:0]    tgt [MEM_N];
    expEntry_t          q [$];
    int                 checks   = 0;
    int                 failures = 0;

    always #5 CLK = ~CLK;

    instr_fetch #(.PC_W(PC_W), .INSTR_W(INSTR_W)) dut (
        .CLK(CLK), .Reset_n(Reset_n), .Start(Start), .StartAddr(StartAddr),
        .IMemAddr(IMemAddr), .IMemRdata(IMemRdata), .Instr(Instr),
        .InstrValid(InstrValid), .Stall(Stall), .branch(branch),
        .branchEq(branchEq), .branchLT(branchLT), .EqFlag(EqFlag),
        .LtFlag(LtFlag), .BranchTarget(BranchTarget), .done(done), .PC(PC),
        .Halted(Halted), .RetireCount(RetireCount)
    );

    // Synchronous instruction memory: address sampled at the edge
    always @(posedge CLK) IMemRdata <= mem[IMemAddr];

    // Toy ISA: opcode 6 = branch, opcode 7 = halt (Func[2] also branches), Func[0]=eq, Func[1]=lt
    function automatic logic isDone(input logic [INSTR_W-1:0] i);
        return i[8:6] == 3'd7;
    endfunction
    function automatic logic isBranch(input logic [INSTR_W-1:0] i);
        return (i[8:6] == 3'd6) || (i[8:6] == 3'd7 && i[5]);
    endfunction

    assign branch       = isBranch(Instr);
    assign branchEq     = Instr[3];
    assign branchLT     = Instr[4];
    assign done         = isDone(Instr);
    assign BranchTarget = tgt[PC];

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [15:0] satInc(input logic [15:0] r);
        return (r == 16'hFFFF) ? r : r + 16'd1;
    endfunction

    // Monitor: every live instruction must match the oldest expected entry
    always @(negedge CLK) begin
        expEntry_t e;
        if (InstrValid) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_valid: got PC=0x%0h expected no live instruction", PC);
            end else begin
                e = q.pop_front();
                check("pc", 32'(PC), 32'(e.pc));
                check("instr", 32'(Instr), 32'(e.instr));
                check("retire", 32'(RetireCount), 32'(e.ret));
                check("halted_in_run", 32'(Halted), 32'd0);
            end
        end
    end

    // Load a program, start it, and let the model predict each live cycle
    task automatic runProgram(input logic [PC_W-1:0] a, input int len, input int stallPct,
                              input bit build, input int abortAt);
        logic [PC_W-1:0]    mpc;
        logic [PC_W-1:0]    ad;
        logic [INSTR_W-1:0] inst;
        logic [15:0]        mret;
        logic [15:0]        holdRet;
        logic [PC_W-1:0]    holdPc;
        logic [2:0]         op;
        bit                 mh;
        bit                 tk;
        int                 n;
        int                 hop;
        if (build) begin
            for (int k = 0; k < len; k++) begin
                ad  = a + PC_W'(k);
                op  = (k == len - 1) ? 3'd7 : 3'($urandom_range(0, 6));
                mem[ad] = {op, 6'($urandom)};
                hop = $urandom_range(1, 6);
                tgt[ad] = (k + hop >= len) ? a + PC_W'(len - 1) : a + PC_W'(k + hop);
            end
        end
        @(posedge CLK); #1;
        Start = 1'b1; StartAddr = a;
        @(posedge CLK); #1;
        Start = 1'b0;
        mpc = a; mret = '0; mh = 1'b0; n = 0;
        while (!mh && n < RUN_MAX) begin
            Stall     = ($urandom_range(0, 99) < stallPct);
            EqFlag    = 1'($urandom);
            LtFlag    = 1'($urandom);
            Start     = 1'($urandom);
            StartAddr = PC_W'($urandom);
            inst = mem[mpc];
            q.push_back('{pc: mpc, instr: inst, ret: mret});
            if (abortAt != 0 && n == abortAt) begin
                #2 Reset_n = 1'b0;
                #1;
                check("abort_valid", 32'(InstrValid), 32'd0);
                check("abort_pc", 32'(PC), 32'd0);
                check("abort_instr", 32'(Instr), 32'd0);
                check("abort_retire", 32'(RetireCount), 32'd0);
                check("abort_halted", 32'(Halted), 32'd0);
                q.delete();
                Start = 1'b0;
                Stall = 1'b0;
                @(posedge CLK); #1;
                Reset_n = 1'b1;
                return;
            end
            if (!Stall) begin
                mret = satInc(mret);
                if (isDone(inst)) begin
                    mh = 1'b1;
                end else begin
                    // Branch taken if unconditional or any selected condition holds
                    tk = isBranch(inst) &&
                         ((!inst[3] && !inst[4]) || (inst[3] && EqFlag) || (inst[4] && LtFlag));
                    mpc = tk ? tgt[mpc] : mpc + PC_W'(1);
                end
            end
            n++;
            @(posedge CLK); #1;
        end
        Start = 1'b0;
        Stall = 1'b0;
        if (!mh) begin
            checks++;
            failures++;
            $display("FAIL run_bound: got no halt after %0d cycles expected halt", n);
        end
        @(negedge CLK);
        check("halted", 32'(Halted), 32'd1);
        check("halt_valid", 32'(InstrValid), 32'd0);
        check("halt_instr", 32'(Instr), 32'd0);
        check("halt_pc", 32'(PC), 32'(mpc));
        check("halt_retire", 32'(RetireCount), 32'(mret));
        check("halt_imemaddr", 32'(IMemAddr), 32'(StartAddr));
        check("queue_drained", 32'(q.size()), 32'd0);
        holdPc  = mpc;
        holdRet = mret;
        repeat (2) begin
            @(posedge CLK); #1;
            Stall = 1'($urandom);
            @(negedge CLK);
            check("halt_hold_pc", 32'(PC), 32'(holdPc));
            check("halt_hold_retire", 32'(RetireCount), 32'(holdRet));
            check("halt_hold_halted", 32'(Halted), 32'd1);
        end
        Stall = 1'b0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b0; StartAddr = 10'h2A5;
        Stall = 1'b0; EqFlag = 1'b0; LtFlag = 1'b0;
        for (int i = 0; i < int'(MEM_N); i++) begin
            mem[i] = INSTR_W'($urandom);
            tgt[i] = PC_W'($urandom);
        end
        #2;
        check("rst_valid", 32'(InstrValid), 32'd0);
        check("rst_halted", 32'(Halted), 32'd0);
        check("rst_pc", 32'(PC), 32'd0);
        check("rst_retire", 32'(RetireCount), 32'd0);
        check("rst_instr", 32'(Instr), 32'd0);
        check("idle_imemaddr", 32'(IMemAddr), 32'h2A5);
        @(posedge CLK); #1;
        Reset_n = 1'b1;

        // Three straight-line instructions then halt from 0x010
        mem[10'h010] = 9'o012;
        mem[10'h011] = 9'o123;
        mem[10'h012] = 9'o234;
        mem[10'h013] = 9'o700;
        runProgram(10'h010, 4, 0, 1'b0, 0);
        check("four_retired", 32'(RetireCount), 32'd4);
        check("four_pc", 32'(PC), 32'h013);

        // Conditional-on-less-than branch into the top of memory, then wrap
        mem[10'h3FD] = {3'd6, 3'b010, 3'd0};
        tgt[10'h3FD] = 10'h3FE;
        mem[10'h3FE] = 9'o055;
        mem[10'h3FF] = 9'o144;
        mem[10'h000] = 9'o740;
        tgt[10'h000] = 10'h2C0;
        runProgram(10'h3FD, 4, 0, 1'b0, 0);
        check("wrap_pc", 32'(PC), 32'h000);

        repeat (8) runProgram(PC_W'($urandom), $urandom_range(4, 40), 25, 1'b1, 0);
        runProgram(10'h3F0, 40, 20, 1'b1, 0);
        runProgram(10'h100, 24, 50, 1'b1, 0);

        // Asynchronous reset mid-run, then a clean restart
        runProgram(10'h155, 60, 10, 1'b1, 5);
        runProgram(10'h155, 12, 0, 1'b1, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
